// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: RV32I opcodes and the PC mux select.
package hazard_ctrl_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode_t;

  // alu_out is encoded as 1 so a branch can select it straight from br_en_ex
  typedef enum logic [1:0] {
    pc_plus4 = 2'd0,
    alu_out  = 2'd1,
    alu_mod2 = 2'd2
  } pcmux_sel_t;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32I core.
// Drives PC load/select and per-stage register enables/flushes for memory
// waits, EX-stage redirects (with wrong-path fetch squash) and load-use stalls.
// Optional macro HAZARD_PERF_CNT_EN builds saturating stall/flush counters;
// without it the counter ports are tied to zero.
// LOAD_USE_STALL is legal in 1..3.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 32,
  localparam int RW            = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic [RW-1:0]    rs1_id,
  input  logic [RW-1:0]    rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [6:0]       opcode_ex,
  input  logic             br_en_ex,
  input  logic [RW-1:0]    rd_ex,
  input  logic             dmem_read_mem,
  input  logic             dmem_write_mem,
  output logic             pc_en,
  output pcmux_sel_t       pcmux_sel,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, SQUASH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        adv, redir, lu;

  assign adv   = dmem_resp | ~(dmem_read_mem | dmem_write_mem);
  assign redir = ((opcode_ex == op_br) & br_en_ex) | (opcode_ex == op_jal) |
                 (opcode_ex == op_jalr);
  assign lu    = (opcode_ex == op_load) & (rd_ex != '0) &
                 ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));

  // PC source select follows the EX opcode regardless of stall or reset
  always_comb begin
    unique case (opcode_ex)
      op_br:   pcmux_sel = br_en_ex ? alu_out : pc_plus4;
      op_jal:  pcmux_sel = alu_out;
      op_jalr: pcmux_sel = alu_mod2;
      default: pcmux_sel = pc_plus4;
    endcase
  end

  // Next-state and stage-control decode; nothing moves unless MEM can advance
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b0;
    IFID_en    = 1'b0;
    IDEX_en    = 1'b0;
    EXMEM_en   = 1'b0;
    MEMWB_en   = 1'b0;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    if (adv) begin
      unique case (state_q)
        RUN: begin
          if (redir) begin
            {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '1;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            state_d    = imem_resp ? RUN : SQUASH;
          end else if (lu) begin
            // hold IF/ID and the PC, inject a bubble into EX
            {IDEX_en, EXMEM_en, MEMWB_en} = '1;
            IDEX_flush = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              cnt_d   = 2'(LOAD_USE_STALL - 2);
              state_d = LU_STALL;
            end
          end else begin
            {IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '1;
            IFID_flush = ~imem_resp;
            pc_en      = imem_resp;
          end
        end
        LU_STALL: begin
          {IDEX_en, EXMEM_en, MEMWB_en} = '1;
          IDEX_flush = 1'b1;
          if (cnt_q == 2'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 2'd1;
        end
        SQUASH: begin
          // wrong-path word still in flight: drop it, PC already holds the target
          {IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = '1;
          IFID_flush = 1'b1;
          if (imem_resp) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    if (!rst_n) begin
      {pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_flush, IDEX_flush} = '0;
    end
  end

  // State and bubble counter; the decode above already holds them when adv=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX holds a bubble while stalling or squashing, so no redirect can appear there
  a_no_redir_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
                                        (state_q != RUN) |-> !redir);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = ((!adv || !IFID_en) && (stall_cnt_q != '1)) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (IDEX_flush && (flush_cnt_q != '1)) ?
                       flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// all compared against a bubble-count/squash-flag reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int NREG  = 32;
  localparam int RW    = $clog2(NREG);
  localparam int L     = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_resp, dmem_resp;
  logic [RW-1:0] rs1_id, rs2_id, rd_ex;
  logic          rs1_used_id, rs2_used_id;
  logic [6:0]    opcode_ex;
  logic          br_en_ex, dmem_read_mem, dmem_write_mem;
  logic          pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_flush, IDEX_flush;
  pcmux_sel_t    pcmux_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  // reference model state: bubbles still owed, wrong-path fetch pending, counters
  int m_bub = 0;
  bit m_sq  = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_ctrl #(.NUM_REGS(NREG), .LOAD_USE_STALL(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id), .opcode_ex(opcode_ex), .br_en_ex(br_en_ex),
    .rd_ex(rd_ex), .dmem_read_mem(dmem_read_mem), .dmem_write_mem(dmem_write_mem),
    .pc_en(pc_en), .pcmux_sel(pcmux_sel), .IFID_en(IFID_en), .IDEX_en(IDEX_en),
    .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en), .IFID_flush(IFID_flush),
    .IDEX_flush(IDEX_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] ov, input logic [31:0] ev);
    tests++;
    assert (ov === ev) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, ov, ev);
    end
  endtask

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0:       return op_br;
      1:       return op_jal;
      2:       return op_jalr;
      3:       return op_load;
      4:       return op_store;
      5:       return op_imm;
      default: return op_reg;
    endcase
  endfunction

  // benign straight-line traffic
  task automatic idle();
    imem_resp = 1'b1; dmem_resp = 1'b0; dmem_read_mem = 1'b0; dmem_write_mem = 1'b0;
    opcode_ex = op_reg; br_en_ex = 1'b0; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0;
  endtask

  task automatic load_use(input logic [RW-1:0] r);
    idle();
    opcode_ex = op_load; rd_ex = r; rs1_id = r; rs1_used_id = 1'b1;
  endtask

  // Check one cycle's outputs against the model, then let the clock edge advance both.
  task automatic step(input string tag);
    bit adv, redir, lu;
    bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_iff, e_idf;
    pcmux_sel_t e_sel;
    int nb;
    bit nsq;
    #1;
    if (!rst_n) begin
      m_bub = 0; m_sq = 1'b0; m_stall = 0; m_flush = 0;
    end
    adv   = dmem_resp || !(dmem_read_mem || dmem_write_mem);
    redir = (opcode_ex == op_br && br_en_ex) || opcode_ex == op_jal || opcode_ex == op_jalr;
    lu    = opcode_ex == op_load && rd_ex != 0 &&
            ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
    case (opcode_ex)
      op_br:   e_sel = br_en_ex ? alu_out : pc_plus4;
      op_jal:  e_sel = alu_out;
      op_jalr: e_sel = alu_mod2;
      default: e_sel = pc_plus4;
    endcase
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_iff, e_idf} = '0;
    nb = m_bub; nsq = m_sq;
    if (rst_n && adv) begin
      if (m_bub > 0) begin
        {e_idex, e_exmem, e_memwb, e_idf} = '1; nb = m_bub - 1;
      end else if (m_sq) begin
        {e_ifid, e_idex, e_exmem, e_memwb, e_iff} = '1;
        if (imem_resp) nsq = 1'b0;
      end else if (redir) begin
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_iff, e_idf} = '1;
        nsq = !imem_resp;
      end else if (lu) begin
        {e_idex, e_exmem, e_memwb, e_idf} = '1; nb = L - 1;
      end else begin
        {e_ifid, e_idex, e_exmem, e_memwb} = '1;
        e_iff = !imem_resp; e_pc = imem_resp;
      end
    end
    chk({tag, ".pc_en"},      32'(pc_en),      32'(e_pc));
    chk({tag, ".pcmux_sel"},  32'(pcmux_sel),  32'(e_sel));
    chk({tag, ".IFID_en"},    32'(IFID_en),    32'(e_ifid));
    chk({tag, ".IDEX_en"},    32'(IDEX_en),    32'(e_idex));
    chk({tag, ".EXMEM_en"},   32'(EXMEM_en),   32'(e_exmem));
    chk({tag, ".MEMWB_en"},   32'(MEMWB_en),   32'(e_memwb));
    chk({tag, ".IFID_flush"}, 32'(IFID_flush), 32'(e_iff));
    chk({tag, ".IDEX_flush"}, 32'(IDEX_flush), 32'(e_idf));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".stall_cnt"},  32'(stall_cnt),  32'(m_stall));
    chk({tag, ".flush_cnt"},  32'(flush_cnt),  32'(m_flush));
`else
    chk({tag, ".stall_cnt"},  32'(stall_cnt),  32'd0);
    chk({tag, ".flush_cnt"},  32'(flush_cnt),  32'd0);
`endif
    if (rst_n) begin
      m_bub = nb; m_sq = nsq;
      if ((!adv || !e_ifid) && m_stall < CMAX) m_stall++;
      if (e_idf && m_flush < CMAX) m_flush++;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    opcode_ex = op_jal;
    @(negedge clk);
    step("reset");
    opcode_ex = op_jalr;
    step("reset_jalr");
    rst_n = 1'b1;
    idle();
    step("run_idle");

    // load-use through rs1, then two bubbles, then normal flow
    load_use(5'd5);
    step("lu_first");
    idle();
    step("lu_bubble2");
    step("lu_done");
    load_use(5'd0);
    step("lu_rd_x0");
    load_use(5'd5); rs1_used_id = 1'b0;
    step("lu_rs1_unused");
    load_use(5'd7); rs1_used_id = 1'b0; rs2_id = 5'd7; rs2_used_id = 1'b1;
    step("lu_rs2");
    idle();
    step("lu_rs2_b2");

    // taken branch with the fetch completing: straight back to RUN
    idle(); opcode_ex = op_br; br_en_ex = 1'b1;
    step("br_taken");
    idle(); opcode_ex = op_br; br_en_ex = 1'b0;
    step("br_not_taken");
    idle(); imem_resp = 1'b0;
    step("fetch_wait");

    // jal with the wrong-path fetch still outstanding
    idle(); opcode_ex = op_jal; imem_resp = 1'b0;
    step("jal_miss");
    idle(); imem_resp = 1'b0;
    step("squash_wait");
    idle(); imem_resp = 1'b1;
    step("squash_drop");
    idle();
    step("after_squash");

    // memory wait in the middle of a load-use stall
    load_use(5'd3);
    step("lu_mw");
    idle(); dmem_read_mem = 1'b1;
    step("mw1");
    step("mw2");
    dmem_resp = 1'b1;
    step("mw3");
    idle();
    step("mw_done");
    idle(); dmem_write_mem = 1'b1; dmem_resp = 1'b1;
    step("store_resp");

    // reset mid-stall, then a fresh hazard gets the full bubble count
    load_use(5'd9);
    step("lu_pre_rst");
    idle(); rst_n = 1'b0;
    step("rst_mid_stall");
    rst_n = 1'b1;
    step("post_rst");
    load_use(5'd9);
    step("lu_after_rst");
    idle();
    step("lu_after_rst_b2");
    step("lu_after_rst_done");

    // long memory wait drives the stall counter into saturation
    idle(); dmem_read_mem = 1'b1;
    for (int i = 0; i < 20; i++) step("long_wait");
    idle();
    step("long_wait_end");

    // random traffic; no redirect is offered while EX is known to hold a bubble
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = (m_bub > 0 || m_sq) ? $urandom_range(3, 6) : $urandom_range(0, 6);
      opcode_ex      = pick_op(k);
      br_en_ex       = 1'($urandom_range(0, 1));
      imem_resp      = ($urandom_range(0, 9) < 6);
      dmem_read_mem  = ($urandom_range(0, 9) < 2);
      dmem_write_mem = ($urandom_range(0, 9) < 1);
      dmem_resp      = 1'($urandom_range(0, 1));
      rd_ex          = 5'($urandom_range(0, 3));
      rs1_id         = 5'($urandom_range(0, 3));
      rs2_id         = 5'($urandom_range(0, 3));
      rs1_used_id    = 1'($urandom_range(0, 1));
      rs2_used_id    = 1'($urandom_range(0, 1));
      rst_n          = ($urandom_range(0, 199) != 0);
      step("rand");
    end
    rst_n = 1'b1;
    idle();
    step("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
